// File: rtl/ps2_rx_fifo_if.sv
// PS/2 receiver bus: raw PS/2 lines, CPU-side pop/clear controls and FIFO/status outputs.
// The master drives the PS/2 lines and CPU controls; the slave is the receiver.
interface ps2_rx_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          ps2_clk;
    logic          ps2_data;
    logic          rd_en;
    logic          err_clear;
    logic [7:0]    data;
    logic          valid;
    logic [LW-1:0] level;
    logic          overflow;
    logic          parity_err;
    logic          frame_err;
    logic          timeout_err;

    modport master (
        output ps2_clk, ps2_data, rd_en, err_clear,
        input  data, valid, level, overflow, parity_err, frame_err, timeout_err
    );

    modport slave (
        input  ps2_clk, ps2_data, rd_en, err_clear,
        output data, valid, level, overflow, parity_err, frame_err, timeout_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with parity/stop/timeout checking and a
// first-word-fall-through FIFO of scan codes.
// Optional glitch filter on the synchronised lines: define PS2_GLITCH_FILTER_EN.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned FILTER_CYCLES  = 8
) (
    input logic           clk,
    input logic           rst,
    ps2_rx_fifo_if.slave  bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("FILTER_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;

    // Shift raw lines through the synchroniser; reset to idle-high so no false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
        end
    end

    logic line_clk;
    logic line_clk_prev;
    logic line_data;

`ifdef PS2_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);

    logic           clk_filt_q, clk_filt_d;
    logic           data_filt_q, data_filt_d;
    logic [FCW-1:0] clk_fcnt_q, clk_fcnt_d;
    logic [FCW-1:0] data_fcnt_q, data_fcnt_d;

    // Filtered value follows the synced line only after FILTER_CYCLES disagreeing cycles.
    always_comb begin
        clk_filt_d  = clk_filt_q;
        clk_fcnt_d  = '0;
        data_filt_d = data_filt_q;
        data_fcnt_d = '0;
        if (clk_sync_q[SYNC_STAGES-1] != clk_filt_q) begin
            if (clk_fcnt_q == FCW'(FILTER_CYCLES - 1)) begin
                clk_filt_d = clk_sync_q[SYNC_STAGES-1];
            end else begin
                clk_fcnt_d = clk_fcnt_q + 1'b1;
            end
        end
        if (data_sync_q[SYNC_STAGES-1] != data_filt_q) begin
            if (data_fcnt_q == FCW'(FILTER_CYCLES - 1)) begin
                data_filt_d = data_sync_q[SYNC_STAGES-1];
            end else begin
                data_fcnt_d = data_fcnt_q + 1'b1;
            end
        end
    end

    // Filter state registers; outputs reset to the idle-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt_q  <= 1'b1;
            data_filt_q <= 1'b1;
            clk_fcnt_q  <= '0;
            data_fcnt_q <= '0;
        end else begin
            clk_filt_q  <= clk_filt_d;
            data_filt_q <= data_filt_d;
            clk_fcnt_q  <= clk_fcnt_d;
            data_fcnt_q <= data_fcnt_d;
        end
    end

    // Edge is seen in the cycle the filtered clock is about to fall.
    assign line_clk      = clk_filt_d;
    assign line_clk_prev = clk_filt_q;
    assign line_data     = data_filt_d;
`else
    assign line_clk      = clk_sync_q[SYNC_STAGES-2];
    assign line_clk_prev = clk_sync_q[SYNC_STAGES-1];
    assign line_data     = data_sync_q[SYNC_STAGES-1];
`endif

    logic strobe;
    assign strobe = line_clk_prev & ~line_clk;

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StShift, StStop} state_e;

    state_e           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       shift_q, shift_d;     // {parity, data[7:0]} once complete
    logic [WDW-1:0]   wd_q, wd_d;
    logic             push;
    logic             set_parity;
    logic             set_frame;
    logic             set_timeout;

    // Next-state: frame sequencing, bit shifting and the mid-frame watchdog.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wd_d        = '0;
        push        = 1'b0;
        set_parity  = 1'b0;
        set_frame   = 1'b0;
        set_timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (strobe && !line_data) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                if (strobe) begin
                    shift_d = {line_data, shift_q[8:1]};
                    if (bit_cnt_q == 4'd8) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = StIdle;
                    set_timeout = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StStop: begin
                if (strobe) begin
                    state_d = StIdle;
                    if (line_data && ^shift_q) begin
                        push = 1'b1;
                    end else if (!line_data) begin
                        set_frame = 1'b1;
                    end else begin
                        set_parity = 1'b1;
                    end
                end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = StIdle;
                    set_timeout = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Decoder state register; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wd_q      <= wd_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [LW-1:0] level_q;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          set_overflow;

    assign pop          = bus.rd_en & (level_q != '0);
    assign full         = (level_q == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok      = push & (~full | pop);
    assign set_overflow = push & full & ~pop;

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= shift_q[7:0];
        end
    end

    // Pointers wrap naturally; level tracks occupancy independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (push_ok && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (!push_ok && pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic overflow_q, parity_err_q, frame_err_q, timeout_err_q;

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            overflow_q    <= (overflow_q    & ~bus.err_clear) | set_overflow;
            parity_err_q  <= (parity_err_q  & ~bus.err_clear) | set_parity;
            frame_err_q   <= (frame_err_q   & ~bus.err_clear) | set_frame;
            timeout_err_q <= (timeout_err_q & ~bus.err_clear) | set_timeout;
        end
    end

    assign bus.data        = mem_q[rptr_q];
    assign bus.valid       = (level_q != '0);
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table of single frames plus
// sequences for overflow, simultaneous push/pop, timeout and mid-frame reset.
module tb_ps2_rx_fifo;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned TMO   = 100;
    localparam int unsigned FILT  = 4;
`ifdef PS2_GLITCH_FILTER_EN
    localparam int unsigned EDGE_DLY = SYNC - 1 + FILT;
`else
    localparam int unsigned EDGE_DLY = SYNC - 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(
        .DEPTH          (DEPTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_CYCLES  (FILT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] code;
        bit         par_ok;
        bit         stop;
        bit         exp_valid;
        logic [7:0] exp_data;
        bit         exp_par;
        bit         exp_frame;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame bits LSB first: start, data[7:0], odd parity, stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_ok,
                                             input bit stop);
        logic p;
        p = ~^b;
        if (!par_ok) p = ~p;
        return {stop, p, b, 1'b0};
    endfunction

    // Clock out the first nbits of a frame; optionally pulse rd_en so that it
    // lands in the same clk cycle as the push caused by the last falling edge.
    task automatic send_bits(input logic [10:0] fr, input int nbits, input bit pop_last);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = fr[i];
            tick(5);
            bus.ps2_clk = 1'b0;
            if (pop_last && i == nbits - 1) begin
                tick(EDGE_DLY);
                bus.rd_en = 1'b1;
                tick(1);
                bus.rd_en = 1'b0;
                tick(10 - EDGE_DLY - 1);
            end else begin
                tick(10);
            end
            bus.ps2_clk = 1'b1;
            tick(5);
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b1, 1'b1), 11, 1'b0);
    endtask

    task automatic do_pop();
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic do_clear();
        bus.err_clear = 1'b1;
        tick(1);
        bus.err_clear = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0};
        vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hAA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

        bus.ps2_clk   = 1'b1;
        bus.ps2_data  = 1'b1;
        bus.rd_en     = 1'b0;
        bus.err_clear = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        check("reset valid", bus.valid, 0);
        check("reset level", bus.level, 0);
        check("reset overflow", bus.overflow, 0);
        check("reset parity_err", bus.parity_err, 0);
        check("reset frame_err", bus.frame_err, 0);
        check("reset timeout_err", bus.timeout_err, 0);

        // Single frames from the table.
        for (int v = 0; v < 6; v++) begin
            send_bits(mk_frame(vecs[v].code, vecs[v].par_ok, vecs[v].stop), 11, 1'b0);
            check($sformatf("vec%0d valid", v), bus.valid, vecs[v].exp_valid);
            check($sformatf("vec%0d level", v), bus.level, vecs[v].exp_valid ? 1 : 0);
            if (vecs[v].exp_valid) check($sformatf("vec%0d data", v), bus.data,
                                         vecs[v].exp_data);
            check($sformatf("vec%0d parity_err", v), bus.parity_err, vecs[v].exp_par);
            check($sformatf("vec%0d frame_err", v), bus.frame_err, vecs[v].exp_frame);
            check($sformatf("vec%0d overflow", v), bus.overflow, 0);
            check($sformatf("vec%0d timeout_err", v), bus.timeout_err, 0);
            if (vecs[v].exp_valid) do_pop();
            do_clear();
            tick(1);
            check($sformatf("vec%0d drained valid", v), bus.valid, 0);
            check($sformatf("vec%0d drained level", v), bus.level, 0);
            check($sformatf("vec%0d cleared parity", v), bus.parity_err, 0);
            check($sformatf("vec%0d cleared frame", v), bus.frame_err, 0);
        end

        // DEPTH+1 frames with no reads: last one dropped.
        for (int k = 1; k <= DEPTH + 1; k++) send(8'(k));
        check("ovf level", bus.level, DEPTH);
        check("ovf flag", bus.overflow, 1);
        for (int k = 1; k <= DEPTH; k++) begin
            check($sformatf("ovf pop%0d data", k), bus.data, k);
            do_pop();
        end
        check("ovf drained valid", bus.valid, 0);
        do_clear();
        tick(1);
        check("ovf cleared", bus.overflow, 0);

        // Push and pop in the same cycle while full.
        for (int k = 1; k <= DEPTH; k++) send(8'(k));
        send_bits(mk_frame(8'(DEPTH + 1), 1'b1, 1'b1), 11, 1'b1);
        check("full push+pop level", bus.level, DEPTH);
        check("full push+pop overflow", bus.overflow, 0);
        for (int k = 2; k <= DEPTH + 1; k++) begin
            check($sformatf("full pp pop%0d data", k), bus.data, k);
            do_pop();
        end
        check("full pp drained", bus.valid, 0);

        // Push and pop in the same cycle with level 1.
        send(8'h33);
        send_bits(mk_frame(8'h44, 1'b1, 1'b1), 11, 1'b1);
        check("lvl1 pp valid", bus.valid, 1);
        check("lvl1 pp level", bus.level, 1);
        check("lvl1 pp data", bus.data, 8'h44);
        do_pop();

        // Watchdog: stall after start + 5 data bits.
        send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 6, 1'b0);
        tick(TMO + 30);
        check("timeout flag", bus.timeout_err, 1);
        check("timeout no push", bus.valid, 0);
        send(8'h5A);
        check("post-timeout valid", bus.valid, 1);
        check("post-timeout data", bus.data, 8'h5A);
        check("post-timeout level", bus.level, 1);
        check("post-timeout parity", bus.parity_err, 0);
        check("post-timeout frame", bus.frame_err, 0);
        do_pop();
        do_clear();
        tick(1);
        check("timeout cleared", bus.timeout_err, 0);

        // Reset mid-frame.
        send_bits(mk_frame(8'h77, 1'b1, 1'b1), 5, 1'b0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("midrst level", bus.level, 0);
        send(8'h29);
        check("midrst post level", bus.level, 1);
        check("midrst post data", bus.data, 8'h29);
        check("midrst parity", bus.parity_err, 0);
        check("midrst frame", bus.frame_err, 0);
        check("midrst timeout", bus.timeout_err, 0);
        check("midrst overflow", bus.overflow, 0);
        do_pop();

`ifdef PS2_GLITCH_FILTER_EN
        // Short low pulses on ps2_clk with data low must not start a frame.
        bus.ps2_data = 1'b0;
        for (int g = 0; g < 4; g++) begin
            bus.ps2_clk = 1'b0;
            tick(3);
            bus.ps2_clk = 1'b1;
            tick(10);
        end
        bus.ps2_data = 1'b1;
        tick(TMO + 30);
        check("glitch level", bus.level, 0);
        check("glitch timeout", bus.timeout_err, 0);
        check("glitch parity", bus.parity_err, 0);
        check("glitch frame", bus.frame_err, 0);
        send(8'h1C);
        check("glitch frame rx valid", bus.valid, 1);
        check("glitch frame rx data", bus.data, 8'h1C);
        do_pop();
`endif

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
